// File: rtl/timer_sched_pkg.sv
// Shared types and helpers for the interval timer scheduler.
package timer_sched_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_e;

  // Preload so the counter reaches 15 after exactly N counts; N=0 loads 0 for 16 counts.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] dur);
    return {CNT_W{1'b0}} - dur;
  endfunction

endpackage

// File: rtl/interval_timer_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [IW-1:0] cand_s;
  logic          hit_s;

  // Walk ptr+1 .. ptr+NREQ and keep the first requester found.
  always_comb begin
    cand_s = ptr;
    valid  = 1'b0;
    idx    = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = (cand_s == IW'(NREQ - 1)) ? '0 : cand_s + IW'(1);
      hit_s  = req[cand_s] & ~valid;
      idx    = hit_s ? cand_s : idx;
      valid  = valid | req[cand_s];
    end
    gnt = valid ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/interval_timer_sched.sv
// Shares one LS161-style counter among NREQ requesters as a round-robin interval timer.
module interval_timer_sched
  import timer_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = CNT_W
) (
  input  logic            CLK,
  input  logic            CLR_n,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ*W-1:0] DUR,
  input  logic            PAUSE,
  output logic [NREQ-1:0] GNT,
  output logic [NREQ-1:0] DONE,
  output logic            BUSY,
  output logic [W-1:0]    CNT_D,
  output logic            CNT_LOAD_n,
  output logic            CNT_ENP,
  output logic            CNT_ENT,
  input  logic            CNT_RCO
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]    load_q, load_d;

  logic [NREQ-1:0] arb_gnt_s;
  logic [IW-1:0]   arb_idx_s;
  logic            arb_valid_s;
  logic [W-1:0]    dur_sel_s;
  logic            req_held_s;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req   (REQ),
    .ptr   (ptr_q),
    .gnt   (arb_gnt_s),
    .idx   (arb_idx_s),
    .valid (arb_valid_s)
  );

  // Duration of the arbitration winner.
  always_comb begin
    dur_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      dur_sel_s = (arb_idx_s == IW'(i)) ? DUR[i*W +: W] : dur_sel_s;
    end
  end

  assign req_held_s = |(REQ & gnt_q);

  // Next-state logic; an abort outranks ripple-carry, and PAUSE blocks the exit.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    load_d  = load_q;
    case (state_q)
      IDLE: begin
        if (arb_valid_s) begin
          state_d = LOAD;
          gnt_d   = arb_gnt_s;
          idx_d   = arb_idx_s;
          load_d  = load_val(dur_sel_s);
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (!req_held_s) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = idx_q;
        end else if (CNT_RCO && !PAUSE) begin
          state_d = FIN;
        end else begin
          state_d = RUN;
        end
      end
      FIN: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = idx_q;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers, cleared together with the shared counter.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= IW'(NREQ - 1);
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      load_q  <= load_d;
    end
  end

  assign GNT        = gnt_q;
  assign DONE       = (state_q == FIN) ? gnt_q : '0;
  assign BUSY       = (state_q != IDLE);
  assign CNT_D      = load_q;
  assign CNT_LOAD_n = (state_q != LOAD);
  assign CNT_ENT    = (state_q == RUN);
  assign CNT_ENP    = (state_q == RUN) & ~PAUSE;

endmodule

// File: tb/tb_interval_timer_sched.sv
// Directed bench for interval_timer_sched with a behavioural LS161-style counter alongside.
module tb_interval_timer_sched;

  logic        CLK = 1'b0;
  logic        CLR_n;
  logic [3:0]  REQ;
  logic [15:0] DUR;
  logic        PAUSE;
  logic [3:0]  GNT, DONE;
  logic        BUSY;
  logic [3:0]  CNT_D;
  logic        CNT_LOAD_n, CNT_ENP, CNT_ENT, CNT_RCO;
  logic [3:0]  q;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  interval_timer_sched #(.NREQ(4), .W(4)) dut (
    .CLK        (CLK),
    .CLR_n      (CLR_n),
    .REQ        (REQ),
    .DUR        (DUR),
    .PAUSE      (PAUSE),
    .GNT        (GNT),
    .DONE       (DONE),
    .BUSY       (BUSY),
    .CNT_D      (CNT_D),
    .CNT_LOAD_n (CNT_LOAD_n),
    .CNT_ENP    (CNT_ENP),
    .CNT_ENT    (CNT_ENT),
    .CNT_RCO    (CNT_RCO)
  );

  // External counter model.
  always @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) q <= 4'd0;
    else if (!CNT_LOAD_n) q <= CNT_D;
    else if (CNT_ENP && CNT_ENT) q <= q + 4'd1;
  end
  assign CNT_RCO = CNT_ENT && (q == 4'd15);

  // Advance negedges from k0 until DONE is nonzero; k_out = -1 if it never comes.
  task automatic wait_done(input int k0, input int max_k, output int k_out, output logic [3:0] d_out);
    int k;
    k = k0;
    k_out = -1;
    d_out = 4'd0;
    while (k < max_k && k_out < 0) begin
      @(negedge CLK);
      k++;
      if (DONE !== 4'd0) begin
        k_out = k;
        d_out = DONE;
      end
    end
  endtask

  task automatic test_reset;
    CLR_n = 1'b0; REQ = 4'd0; DUR = 16'd0; PAUSE = 1'b0;
    #12;
    checks++;
    if ({GNT, DONE, BUSY, CNT_D} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outs: got gnt=%b done=%b busy=%b d=%0d, expected all zero", GNT, DONE, BUSY, CNT_D);
    end
    checks++;
    if ({CNT_LOAD_n, CNT_ENP, CNT_ENT} !== 3'b100) begin
      failures++;
      $display("FAIL reset_ctl: got load_n/enp/ent=%b expected 100", {CNT_LOAD_n, CNT_ENP, CNT_ENT});
    end
    @(negedge CLK);
    CLR_n = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_round_robin;
    logic [3:0] g[5];
    int t[5];
    int n;
    logic [3:0] prev;
    logic [3:0] exp_g[5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    n = 0; prev = 4'd0;
    for (int i = 0; i < 5; i++) begin g[i] = 4'd0; t[i] = 0; end
    REQ = 4'b1111; DUR = 16'h2222;
    for (int k = 1; k <= 24; k++) begin
      @(negedge CLK);
      if (GNT !== 4'd0 && prev === 4'd0 && n < 5) begin
        g[n] = GNT; t[n] = k; n++;
      end
      prev = GNT;
    end
    REQ = 4'd0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (g[i] !== exp_g[i] || t[i] !== 1 + 5 * i) begin
        failures++;
        $display("FAIL rr_grant%0d: got gnt=%b at cycle %0d, expected %b at cycle %0d", i, g[i], t[i], exp_g[i], 1 + 5 * i);
      end
    end
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL rr_drain: busy=%b expected 0", BUSY);
    end
  endtask

  task automatic test_single;
    int k;
    logic [3:0] d;
    REQ = 4'b0001; DUR = {4'd0, 4'd0, 4'd0, 4'd5};
    @(negedge CLK);
    checks++;
    if (GNT !== 4'b0001 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL single_gnt: got gnt=%b busy=%b expected 0001 1", GNT, BUSY);
    end
    checks++;
    if (CNT_LOAD_n !== 1'b0 || CNT_D !== 4'd11 || CNT_ENP !== 1'b0 || CNT_ENT !== 1'b0) begin
      failures++;
      $display("FAIL single_load: got load_n=%b d=%0d enp=%b ent=%b expected 0 11 0 0", CNT_LOAD_n, CNT_D, CNT_ENP, CNT_ENT);
    end
    DUR = 16'h0000;
    wait_done(1, 30, k, d);
    REQ = 4'd0;
    checks++;
    if (k !== 7 || d !== 4'b0001) begin
      failures++;
      $display("FAIL single_done: got done=%b at cycle %0d expected 0001 at cycle 7", d, k);
    end
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || DONE !== 4'd0 || GNT !== 4'd0) begin
      failures++;
      $display("FAIL single_after: got busy=%b done=%b gnt=%b expected all zero", BUSY, DONE, GNT);
    end
  endtask

  task automatic test_extremes;
    int k;
    logic [3:0] d;
    logic [3:0] durs[2];
    int exp_k[2];
    logic [3:0] exp_d[2];
    durs[0] = 4'd1; exp_k[0] = 3;  exp_d[0] = 4'd15;
    durs[1] = 4'd0; exp_k[1] = 18; exp_d[1] = 4'd0;
    for (int i = 0; i < 2; i++) begin
      REQ = 4'b0001; DUR = {12'd0, durs[i]};
      @(negedge CLK);
      checks++;
      if (CNT_D !== exp_d[i] || CNT_LOAD_n !== 1'b0) begin
        failures++;
        $display("FAIL extreme_load%0d: got d=%0d load_n=%b expected %0d 0", i, CNT_D, CNT_LOAD_n, exp_d[i]);
      end
      wait_done(1, 40, k, d);
      REQ = 4'd0;
      checks++;
      if (k !== exp_k[i] || d !== 4'b0001) begin
        failures++;
        $display("FAIL extreme_done%0d: got done=%b at cycle %0d expected 0001 at cycle %0d", i, d, k, exp_k[i]);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_pause;
    int kd;
    kd = -1;
    REQ = 4'b0001; DUR = {12'd0, 4'd4};
    for (int k = 1; k <= 15; k++) begin
      @(negedge CLK);
      PAUSE = (k >= 5 && k <= 7);
      #1;
      if (k == 5) begin
        checks++;
        if (q !== 4'd15 || CNT_RCO !== 1'b1 || CNT_ENP !== 1'b0 || BUSY !== 1'b1) begin
          failures++;
          $display("FAIL pause_q15: got q=%0d rco=%b enp=%b busy=%b expected 15 1 0 1", q, CNT_RCO, CNT_ENP, BUSY);
        end
      end
      if (DONE !== 4'd0 && kd < 0) kd = k;
      if (kd == k) REQ = 4'd0;
    end
    PAUSE = 1'b0;
    checks++;
    if (kd !== 9) begin
      failures++;
      $display("FAIL pause_done: got done at cycle %0d expected cycle 9", kd);
    end
  endtask

  task automatic test_abort;
    logic seen;
    int k;
    logic [3:0] d;
    seen = 1'b0;
    REQ = 4'b1100; DUR = {4'd1, 4'd8, 8'd0};
    @(negedge CLK);
    checks++;
    if (GNT !== 4'b0100) begin
      failures++;
      $display("FAIL abort_gnt: got %b expected 0100", GNT);
    end
    for (int kk = 2; kk <= 5; kk++) begin
      @(negedge CLK);
      if (kk == 4) REQ = 4'b1000;
      if (DONE !== 4'd0) seen = 1'b1;
      if (kk == 5) begin
        checks++;
        if (GNT !== 4'd0) begin
          failures++;
          $display("FAIL abort_clear: got gnt=%b expected 0000", GNT);
        end
      end
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_nodone: got a done pulse, expected none");
    end
    @(negedge CLK);
    checks++;
    if (GNT !== 4'b1000) begin
      failures++;
      $display("FAIL abort_next: got gnt=%b expected 1000", GNT);
    end
    wait_done(6, 20, k, d);
    REQ = 4'd0;
    checks++;
    if (k !== 8 || d !== 4'b1000) begin
      failures++;
      $display("FAIL abort_next_done: got done=%b at cycle %0d expected 1000 at cycle 8", d, k);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    int k;
    logic [3:0] d;
    REQ = 4'b0010; DUR = {8'd0, 4'd1, 4'd0};
    wait_done(0, 20, k, d);
    REQ = 4'd0;
    checks++;
    if (d !== 4'b0010) begin
      failures++;
      $display("FAIL rst_pre: got done=%b expected 0010", d);
    end
    @(negedge CLK);
    REQ = 4'b0001; DUR = {12'd0, 4'd8};
    repeat (4) @(negedge CLK);
    #2;
    CLR_n = 1'b0;
    #1;
    checks++;
    if ({GNT, DONE, BUSY, CNT_D, CNT_LOAD_n, CNT_ENP, CNT_ENT} !== 16'b0000_0000_0_0000_100) begin
      failures++;
      $display("FAIL rst_mid: got gnt=%b done=%b busy=%b d=%0d load_n=%b enp=%b ent=%b", GNT, DONE, BUSY, CNT_D, CNT_LOAD_n, CNT_ENP, CNT_ENT);
    end
    @(negedge CLK);
    REQ = 4'b1010;
    CLR_n = 1'b1;
    @(negedge CLK);
    checks++;
    if (GNT !== 4'b0010) begin
      failures++;
      $display("FAIL rst_prio: got gnt=%b expected 0010", GNT);
    end
    REQ = 4'd0;
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_single;
    test_extremes;
    test_pause;
    test_abort;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
